// File: rtl/fib_seq_gen_pkg.sv
// Shared definitions for the generalised Fibonacci sequence generator:
// FSM state encoding and job mode constants.
package fib_pkg;

  // Controller states. The enum documents the encoding; the FSM itself
  // works on the plain logic constants below so that older tooling and
  // netlist probes keep seeing a fixed 2-bit vector.
  typedef enum logic [1:0] {
    FIB_IDLE = 2'b00,
    FIB_CALC = 2'b01,
    FIB_EMIT = 2'b10
  } fib_state_e;

  localparam logic [1:0] ST_IDLE = FIB_IDLE;
  localparam logic [1:0] ST_CALC = FIB_CALC;
  localparam logic [1:0] ST_EMIT = FIB_EMIT;

  // Job modes: return only term n, or stream terms 0..n.
  localparam logic FIB_MODE_SINGLE = 1'b0;
  localparam logic FIB_MODE_STREAM = 1'b1;

endpackage

// File: rtl/fib_seq_gen_if.sv
// Request / result bundle of the sequence generator. The master side
// issues jobs and consumes beats; the slave side is the generator.
interface fib_seq_gen_if #(
  parameter int WIDTH   = 16,
  parameter int N_WIDTH = 8
);

  // Job request
  logic               i_stb;
  logic               i_mode;
  logic [N_WIDTH-1:0] i_n;
  logic [WIDTH-1:0]   i_seed0;
  logic [WIDTH-1:0]   i_seed1;

  // Beat handshake and status
  logic               i_ready;
  logic               o_busy;
  logic               o_valid;
  logic [WIDTH-1:0]   o_term;
  logic [N_WIDTH-1:0] o_index;
  logic               o_last;
  logic               o_ovf;

  modport master (
    output i_stb, i_mode, i_n, i_seed0, i_seed1, i_ready,
    input  o_busy, o_valid, o_term, o_index, o_last, o_ovf
  );

  modport slave (
    input  i_stb, i_mode, i_n, i_seed0, i_seed1, i_ready,
    output o_busy, o_valid, o_term, o_index, o_last, o_ovf
  );

endinterface

// File: rtl/fib_seq_gen_step.sv
// One recurrence step: b_next = a + b with carry-based overflow tagging.
// Tags are sticky through the chain, so a term derived from an overflowed
// term is itself marked overflowed. With SATURATE set, every tagged term
// is clamped to all-ones; otherwise it wraps modulo 2^WIDTH.
module fib_step #(
  parameter int WIDTH    = 16,
  parameter int SATURATE = 1
) (
  input  logic [WIDTH-1:0] a_s,
  input  logic [WIDTH-1:0] b_s,
  input  logic             a_ovf_s,
  input  logic             b_ovf_s,
  output logic [WIDTH-1:0] b_next_s,
  output logic             b_ovf_next_s
);

  logic [WIDTH:0] sum_s;

  // Widened add, sticky overflow tag and optional clamp of the next term.
  always_comb begin
    sum_s        = {1'b0, a_s} + {1'b0, b_s};
    b_ovf_next_s = sum_s[WIDTH] | a_ovf_s | b_ovf_s;
    if ((SATURATE != 0) && b_ovf_next_s) begin
      b_next_s = '1;
    end else begin
      b_next_s = sum_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fib_seq_gen.sv
// Generalised Fibonacci (Lucas-type) sequence generator.
// A strobe in IDLE starts a job from two seeds. Single mode walks the
// recurrence silently up to term n and emits one beat; stream mode emits
// every term 0..n over a valid/ready handshake. All status outputs are
// flops; the beat payload comes straight from the a/k registers, so
// i_ready never reaches an output combinationally.
module fib_seq_gen
  import fib_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int N_WIDTH  = 8,
  parameter int SATURATE = 1
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  fib_seq_gen_if.slave  bus
);

  // Architectural state
  logic [1:0]         state_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic               a_ovf_r;
  logic               b_ovf_r;
  logic [N_WIDTH-1:0] k_r;
  logic [N_WIDTH-1:0] n_r;
  logic               mode_r;

  // Registered outputs
  logic               busy_r;
  logic               valid_r;
  logic               last_r;
  logic               ovf_r;

  // Next-state values
  logic [1:0]         state_s;
  logic [WIDTH-1:0]   a_s;
  logic [WIDTH-1:0]   b_s;
  logic               a_ovf_s;
  logic               b_ovf_s;
  logic [N_WIDTH-1:0] k_s;
  logic [N_WIDTH-1:0] n_s;
  logic               mode_s;
  logic               ovf_base_s;
  logic               ovf_s;
  logic               last_s;

  // Step datapath outputs
  logic [WIDTH-1:0]   step_b_s;
  logic               step_b_ovf_s;

  fib_step #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_step (
    .a_s          (a_r),
    .b_s          (b_r),
    .a_ovf_s      (a_ovf_r),
    .b_ovf_s      (b_ovf_r),
    .b_next_s     (step_b_s),
    .b_ovf_next_s (step_b_ovf_s)
  );

  // FSM: job acceptance, silent calculation and beat emission.
  always_comb begin
    state_s    = state_r;
    a_s        = a_r;
    b_s        = b_r;
    a_ovf_s    = a_ovf_r;
    b_ovf_s    = b_ovf_r;
    k_s        = k_r;
    n_s        = n_r;
    mode_s     = mode_r;
    ovf_base_s = ovf_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.i_stb) begin
          n_s        = bus.i_n;
          mode_s     = bus.i_mode;
          a_s        = bus.i_seed0;
          b_s        = bus.i_seed1;
          a_ovf_s    = 1'b0;
          b_ovf_s    = 1'b0;
          k_s        = '0;
          ovf_base_s = 1'b0;
          state_s    = (bus.i_mode == FIB_MODE_SINGLE) ? ST_CALC : ST_EMIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (k_r == n_r) begin
          state_s = ST_EMIT;
        end else begin
          a_s     = b_r;
          a_ovf_s = b_ovf_r;
          b_s     = step_b_s;
          b_ovf_s = step_b_ovf_s;
          k_s     = k_r + N_WIDTH'(1);
        end
      end
      ST_EMIT: begin
        if (valid_r && bus.i_ready) begin
          if (last_r) begin
            state_s = ST_IDLE;
          end else if (mode_r == FIB_MODE_STREAM) begin
            a_s     = b_r;
            a_ovf_s = b_ovf_r;
            b_s     = step_b_s;
            b_ovf_s = step_b_ovf_s;
            k_s     = k_r + N_WIDTH'(1);
          end else begin
            // Single mode always presents its only beat as last.
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_EMIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode of the next state: overflow only counts for terms that
  // are actually presented, never for the look-ahead term in b.
  always_comb begin
    ovf_s  = ovf_base_s | ((state_s == ST_EMIT) & a_ovf_s);
    last_s = (state_s == ST_EMIT) && (k_s == n_s);
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r <= ST_IDLE;
      a_r     <= '0;
      b_r     <= '0;
      a_ovf_r <= 1'b0;
      b_ovf_r <= 1'b0;
      k_r     <= '0;
      n_r     <= '0;
      mode_r  <= FIB_MODE_SINGLE;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      a_r     <= a_s;
      b_r     <= b_s;
      a_ovf_r <= a_ovf_s;
      b_ovf_r <= b_ovf_s;
      k_r     <= k_s;
      n_r     <= n_s;
      mode_r  <= mode_s;
      busy_r  <= (state_s != ST_IDLE);
      valid_r <= (state_s == ST_EMIT);
      last_r  <= last_s;
      ovf_r   <= ovf_s;
    end
  end

  assign bus.o_busy  = busy_r;
  assign bus.o_valid = valid_r;
  assign bus.o_term  = a_r;
  assign bus.o_index = k_r;
  assign bus.o_last  = last_r;
  assign bus.o_ovf   = ovf_r;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Bench for fib_seq_gen: a saturating and a wrapping instance run in
// lockstep on the same stimulus, each with its own expected-beat queue.
module tb_fib_seq_gen;

  typedef struct packed {
    logic        valid;
    logic [15:0] term;
    logic [7:0]  index;
    logic        last;
    logic        ovf;
  } beat_t;

  typedef struct {
    bit          mode;
    int          n;
    int          s0;
    int          s1;
    logic [15:0] rdy;
    int          first;
    logic [15:0] fin_sat;
    logic [15:0] fin_wrap;
    bit          fin_ovf;
    int          mid_stb;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0;
  logic        mode = 1'b0;
  logic        ready = 1'b0;
  logic [7:0]  n = 8'd0;
  logic [15:0] s0 = 16'd0;
  logic [15:0] s1 = 16'd0;

  int total = 0;
  int bad   = 0;

  beat_t q_sat[$];
  beat_t q_wrap[$];

  always #5 clk = ~clk;

  fib_seq_gen_if #(.WIDTH(16), .N_WIDTH(8)) if_sat ();
  fib_seq_gen_if #(.WIDTH(16), .N_WIDTH(8)) if_wrap ();

  assign if_sat.i_stb    = stb;
  assign if_sat.i_mode   = mode;
  assign if_sat.i_n      = n;
  assign if_sat.i_seed0  = s0;
  assign if_sat.i_seed1  = s1;
  assign if_sat.i_ready  = ready;
  assign if_wrap.i_stb   = stb;
  assign if_wrap.i_mode  = mode;
  assign if_wrap.i_n     = n;
  assign if_wrap.i_seed0 = s0;
  assign if_wrap.i_seed1 = s1;
  assign if_wrap.i_ready = ready;

  fib_seq_gen #(.WIDTH(16), .N_WIDTH(8), .SATURATE(1)) dut_sat (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (if_sat)
  );

  fib_seq_gen #(.WIDTH(16), .N_WIDTH(8), .SATURATE(0)) dut_wrap (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (if_wrap)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: exact term from unbounded arithmetic, then clamp or wrap.
  function automatic beat_t model(int a0, int a1, int k, bit sat, bit last);
    beat_t  r;
    longint x;
    longint y;
    longint t;
    x = a0;
    y = a1;
    for (int i = 0; i < k; i++) begin
      t = x + y;
      x = y;
      y = t;
    end
    r.valid = 1'b1;
    r.ovf   = (x >= 65536);
    r.term  = (sat && r.ovf) ? 16'hffff : x[15:0];
    r.index = k[7:0];
    r.last  = last;
    return r;
  endfunction

  function automatic beat_t cur(bit wrap_sel);
    beat_t r;
    if (wrap_sel) r = {if_wrap.o_valid, if_wrap.o_term, if_wrap.o_index, if_wrap.o_last, if_wrap.o_ovf};
    else          r = {if_sat.o_valid, if_sat.o_term, if_sat.o_index, if_sat.o_last, if_sat.o_ovf};
    return r;
  endfunction

  task automatic push_job(input bit m, input int nn, input int a0, input int a1);
    for (int k = 0; k <= nn; k++) begin
      if (m || (k == nn)) begin
        q_sat.push_back(model(a0, a1, k, 1'b1, k == nn));
        q_wrap.push_back(model(a0, a1, k, 1'b0, k == nn));
      end
    end
  endtask

  task automatic start_job(input bit m, input int nn, input int a0, input int a1);
    @(posedge clk);
    #1;
    stb  = 1'b1;
    mode = m;
    n    = nn[7:0];
    s0   = a0[15:0];
    s1   = a1[15:0];
    @(posedge clk);
    #1;
    stb = 1'b0;
    chk("busy_rise", {30'd0, if_sat.o_busy, if_wrap.o_busy}, 32'd3);
  endtask

  // Consume beats against the scoreboard, checking stalls stay stable.
  task automatic drain(input logic [15:0] rdy, input int exp_first, input int mid_stb,
                       input int stop_idx, output beat_t fin_s, output beat_t fin_w,
                       output bit stopped);
    int    c = 0;
    int    first = -1;
    bit    hold = 1'b0;
    beat_t held_s, held_w, bs, bw, es, ew;
    fin_s   = '0;
    fin_w   = '0;
    stopped = 1'b0;
    while ((q_sat.size() > 0) && (c < 200) && !stopped) begin
      ready = rdy[c % 16];
      if (c == mid_stb) begin
        stb = 1'b1;
        n   = 8'd3;
        s0  = 16'd9;
        s1  = 16'd9;
      end else begin
        stb = 1'b0;
      end
      @(negedge clk);
      bs = cur(1'b0);
      bw = cur(1'b1);
      if (hold) begin
        chk("stall_sat", 32'(bs), 32'(held_s));
        chk("stall_wrap", 32'(bw), 32'(held_w));
      end
      hold = 1'b0;
      if (bs.valid && (first < 0)) first = c;
      if (bs.valid && (stop_idx >= 0) && (int'(bs.index) == stop_idx)) begin
        stopped = 1'b1;
      end else if (bs.valid && ready) begin
        es = q_sat.pop_front();
        ew = q_wrap.pop_front();
        chk("beat_sat", 32'(bs), 32'(es));
        chk("beat_wrap", 32'(bw), 32'(ew));
        fin_s = bs;
        fin_w = bw;
      end else if (bs.valid) begin
        hold   = 1'b1;
        held_s = bs;
        held_w = bw;
      end
      if (!stopped) begin
        @(posedge clk);
        #1;
        c++;
      end
    end
    stb = 1'b0;
    if (!stopped) begin
      chk("drain_left", q_sat.size(), 32'd0);
      chk("first_valid", first, exp_first);
      chk("fall", {28'd0, if_sat.o_busy, if_sat.o_valid, if_wrap.o_busy, if_wrap.o_valid}, 32'd0);
    end
  endtask

  vec_t  vecs[10];
  beat_t fs, fw;
  bit    stopped;

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    //        mode n   s0 s1 rdy       first fin_sat    fin_wrap   ovf mid
    vecs[0] = '{1'b0, 10, 0, 1, 16'hffff, 11, 16'd55,    16'd55,    1'b0, -1};
    vecs[1] = '{1'b1, 5,  0, 1, 16'hffff, 0,  16'd5,     16'd5,     1'b0, -1};
    vecs[2] = '{1'b1, 5,  0, 1, 16'h9999, 0,  16'd5,     16'd5,     1'b0, -1};
    vecs[3] = '{1'b0, 24, 0, 1, 16'hffff, 25, 16'd46368, 16'd46368, 1'b0, -1};
    vecs[4] = '{1'b0, 25, 0, 1, 16'hffff, 26, 16'hffff,  16'd9489,  1'b1, -1};
    vecs[5] = '{1'b1, 0,  7, 9, 16'hffff, 0,  16'd7,     16'd7,     1'b0, -1};
    vecs[6] = '{1'b0, 1,  3, 4, 16'hffff, 2,  16'd4,     16'd4,     1'b0, -1};
    vecs[7] = '{1'b1, 26, 0, 1, 16'hffff, 0,  16'hffff,  16'd55857, 1'b1, -1};
    vecs[8] = '{1'b0, 0,  5, 6, 16'h0004, 1,  16'd5,     16'd5,     1'b0, -1};
    vecs[9] = '{1'b0, 6,  2, 1, 16'hffff, 7,  16'd18,    16'd18,    1'b0, 3};

    #12;
    chk("reset_sat", 32'(cur(1'b0)), 32'd0);
    chk("reset_wrap", 32'(cur(1'b1)), 32'd0);
    chk("reset_busy", {30'd0, if_sat.o_busy, if_wrap.o_busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      push_job(vecs[i].mode, vecs[i].n, vecs[i].s0, vecs[i].s1);
      start_job(vecs[i].mode, vecs[i].n, vecs[i].s0, vecs[i].s1);
      drain(vecs[i].rdy, vecs[i].first, vecs[i].mid_stb, -1, fs, fw, stopped);
      chk($sformatf("final_sat_%0d", i), {16'd0, fs.term}, {16'd0, vecs[i].fin_sat});
      chk($sformatf("final_wrap_%0d", i), {16'd0, fw.term}, {16'd0, vecs[i].fin_wrap});
      chk($sformatf("final_ovf_%0d", i), {30'd0, fs.ovf, fw.ovf}, {30'd0, vecs[i].fin_ovf, vecs[i].fin_ovf});
    end

    // Reset in the middle of a stream, at beat 7.
    push_job(1'b1, 20, 0, 1);
    start_job(1'b1, 20, 0, 1);
    drain(16'hffff, 0, -1, 7, fs, fw, stopped);
    chk("stop_at_7", {31'd0, stopped}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sat", 32'(cur(1'b0)), 32'd0);
    chk("async_rst_wrap", 32'(cur(1'b1)), 32'd0);
    chk("async_rst_busy", {30'd0, if_sat.o_busy, if_wrap.o_busy}, 32'd0);
    q_sat.delete();
    q_wrap.delete();
    #4;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_beat_after_rst", {28'd0, if_sat.o_valid, if_sat.o_busy, if_wrap.o_valid, if_wrap.o_busy}, 32'd0);
    end

    // n=0 stream job after reset returns seed0 as the last beat.
    push_job(1'b1, 0, 16'habc, 1);
    start_job(1'b1, 0, 16'habc, 1);
    drain(16'hffff, 0, -1, -1, fs, fw, stopped);
    chk("post_rst_term", {16'd0, fs.term}, 32'h0abc);
    chk("post_rst_last", {31'd0, fs.last}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fib_seq_gen.md
# fib_seq_gen

Parametrised successor to the 8-bit `fib` engine. It generates terms of a generalised Fibonacci (Lucas-type) sequence from two programmable seeds. It has two modes: single-result mode returns only term n, and streaming mode emits terms 0..n through a valid/ready handshake. It adds overflow detection with an optional saturating mode. It sits behind the tile wrapper and is driven by a strobe, like its predecessor.

## Interface
Parameters:
- `WIDTH`, 16, term width in bits.
- `N_WIDTH`, 8, width of the term index n.
- `SATURATE`, 1: 1 = terms clamp to all-ones on overflow; 0 = terms wrap modulo 2^WIDTH.

Ports:
- `i_clk`  in  1  clock; single clock domain.
- `i_reset_n`  in  1  reset, asynchronous, active-low.
- `i_stb`  in  1  start request; sampled only in IDLE.
- `i_mode`  in  1  0 = single result (term n only); 1 = stream terms 0..n.
- `i_n`  in  N_WIDTH  index of the last term.
- `i_seed0`  in  WIDTH  term 0.
- `i_seed1`  in  WIDTH  term 1.
- `i_ready`  in  1  consumer accepts the current beat.
- `o_busy`  out  1  high whenever state ≠ IDLE.
- `o_valid`  out  1  `o_term`/`o_index` hold a valid beat.
- `o_term`  out  WIDTH  term value.
- `o_index`  out  N_WIDTH  index of `o_term`.
- `o_last`  out  1  current beat is the final beat of the job (index n).
- `o_ovf`  out  1  sticky overflow flag for the current job.

## Operation
Registers:
- `a`, `b`: current term and next term.
- `k`: index of `a`.
- Latched `n` and `mode`.
- `a_ovf`, `b_ovf`: per-register overflow tags.

States:
- **IDLE**
  - On `i_stb`: latch `i_n` and `i_mode`; load `a=i_seed0`, `b=i_seed1`, `k=0`, both tags 0; clear `o_ovf`.
  - Next state is CALC if `mode=0`, otherwise EMIT.
- **CALC** (mode 0, no output beats)
  - If `k==n`, go to EMIT.
  - Otherwise step: `a←b`, `a_ovf←b_ovf`, `b←a+b`, `k←k+1`.
- **EMIT**
  - `o_valid=1`, `o_term=a`, `o_index=k`.
  - `o_last=1` when `k==n` (always 1 in mode 0).
  - On `o_valid && i_ready`:
    - If `o_last`, return to IDLE.
    - Otherwise (mode 1 only) perform one step and stay in EMIT.

Arithmetic:
- Step sum is WIDTH+1 bits; the carry is the overflow bit.
- `b_ovf_next = carry | a_ovf | b_ovf`.
- With `SATURATE=1`, `b_next` is forced to all-ones whenever `b_ovf_next` is set. With `SATURATE=0`, `b_next` is the low WIDTH bits of the sum.
- `o_ovf` is set when any emitted beat (mode 1), or the final term (mode 0), has `a_ovf=1`. It stays set until the next accepted `i_stb`.
- Overflow of `b` beyond term n never raises `o_ovf`.

Boundary conditions:
- `n=0`: one beat, `seed0`, with `o_last=1`.
- `n=1` in mode 0: one step, result `seed1`.
- `i_stb` while busy is ignored; latched operands do not change.
- `i_ready` held low: the beat and all outputs stay stable indefinitely.
- `i_reset_n` low at any time: immediately go to IDLE with all outputs 0. No partial beat is issued after release.

## Timing
- Reset values: `o_busy`, `o_valid`, `o_term`, `o_index`, `o_last`, `o_ovf` are all 0.
- Acceptance edge E0 is the edge at which IDLE samples `i_stb=1`. `o_busy` rises after E0.
- Mode 0: `o_valid` rises after edge E0+n+1 (n+1 CALC cycles).
- Mode 1: the first beat (index 0) is valid after E0. With `i_ready` held high, one beat is issued per cycle, with the last beat after E0+n.
- After the final handshake edge, `o_valid` and `o_busy` fall in the same cycle. A new `i_stb` is accepted at the next edge at the earliest.
- No combinational path from `i_ready` to `o_valid`/`o_term`.

## Structure
- Package `fib_pkg` holds:
  - The state enum: IDLE, CALC, EMIT.
  - Mode constants `FIB_MODE_SINGLE=0` and `FIB_MODE_STREAM=1`.
- Sub-module `fib_step`: a purely combinational block that computes `(b_next, b_ovf_next)` from `a`, `b` and the tags, and applies the SATURATE parameter.
- The top holds the FSM, counter and handshake.

## Test plan
- Mode 0, seeds 0/1, n=10 → single beat after E0+11: `o_term=55`, `o_index=10`, `o_last=1`, `o_ovf=0`.
- Mode 1, seeds 0/1, n=5, `i_ready=1` → six consecutive beats 0,1,1,2,3,5 with `o_index` 0..5; `o_last` only on 5; `o_busy` falls afterwards.
- Mode 1, n=5, `i_ready` toggled 1-0-0-1… → the same six values in order; outputs are stable while `i_ready=0`.
- Default WIDTH=16, mode 0:
  - n=24 → 46368, `o_ovf=0`.
  - n=25 with `SATURATE=1` → 0xFFFF, `o_ovf=1`.
  - n=25 with `SATURATE=0` → 9489, `o_ovf=1`.
- Mode 0, seeds 2/1 (Lucas), n=6 → 18. A second `i_stb` pulsed mid-job (n=3) is ignored.
- Mode 1, n=20: drop `i_reset_n` at beat 7 → all outputs go to 0 asynchronously. After release, a job with n=0 returns `seed0` with `o_last=1`.
